// File: rtl/ctrl_pipe_tracker_if.sv
// Issue/commit bundle for ctrl_pipe_tracker.
// master drives issue-side controls, slave (the tracker) drives taps and status.
interface ctrl_pipe_tracker_if #(
    parameter int CTRL_W  = 27,
    parameter int STAGES  = 69,
    parameter int N_TAPS  = 5,
    parameter int THREADS = 4,
    parameter int CNT_W   = 24
);
    localparam int TH_W = (THREADS > 1) ? $clog2(THREADS) : 1;
    localparam int IF_W = $clog2(STAGES + 1);

    logic                     flush;
    logic                     busy;
    logic                     issue_valid;
    logic [CTRL_W-1:0]        issue_ctrl;
    logic [TH_W-1:0]          issue_thread;
    logic [THREADS-1:0]       thread_en;
    logic [N_TAPS-1:0]        tap_valid;
    logic [N_TAPS*TH_W-1:0]   tap_thread;
    logic [N_TAPS*CTRL_W-1:0] tap_ctrl;
    logic                     wr_valid;
    logic [TH_W-1:0]          wr_thread;
    logic [CTRL_W-1:0]        wr_ctrl;
    logic [IF_W-1:0]          inflight;
    logic                     drained;
    logic [CNT_W-1:0]         cycle_cnt;
    logic                     parity_err;

    modport master (
        output flush, busy, issue_valid, issue_ctrl, issue_thread, thread_en,
        input  tap_valid, tap_thread, tap_ctrl, wr_valid, wr_thread, wr_ctrl,
        input  inflight, drained, cycle_cnt, parity_err
    );

    modport slave (
        input  flush, busy, issue_valid, issue_ctrl, issue_thread, thread_en,
        output tap_valid, tap_thread, tap_ctrl, wr_valid, wr_thread, wr_ctrl,
        output inflight, drained, cycle_cnt, parity_err
    );
endinterface

// File: rtl/ctrl_pipe_tracker.sv
// Control-word delay pipe with taps, gated write commit, drain and busy counters.
// Optional per-stage parity checking is enabled by CTRL_PIPE_PARITY_EN.
module ctrl_pipe_tracker #(
    parameter int                  CTRL_W  = 27,
    parameter int                  STAGES  = 69,
    parameter int                  N_TAPS  = 5,
    parameter logic [N_TAPS*8-1:0] TAP_POS = {8'd68, 8'd67, 8'd66, 8'd65, 8'd2},
    parameter int                  THREADS = 4,
    parameter int                  CNT_W   = 24
) (
    input  logic               clk,
    input  logic               rst,
    ctrl_pipe_tracker_if.slave bus
);
    localparam int TH_W = (THREADS > 1) ? $clog2(THREADS) : 1;
    localparam int IF_W = $clog2(STAGES + 1);
    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] vld_q;
    logic [TH_W-1:0]   thr_q [STAGES];
    logic [CTRL_W-1:0] ctl_q [STAGES];
    logic [CTRL_W-1:0] issue_word;
    logic [IF_W-1:0]   inflight_q, inflight_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept, retire;

    assign issue_word = bus.issue_valid ? bus.issue_ctrl : '0;
    assign accept     = bus.issue_valid & ~bus.flush;
    assign retire     = vld_q[LAST];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                thr_q[i] <= '0;
                ctl_q[i] <= '0;
            end
        end else if (bus.flush) begin
            vld_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                thr_q[i] <= '0;
                ctl_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= bus.issue_valid;
            thr_q[0] <= bus.issue_thread;
            ctl_q[0] <= issue_word;
            for (int i = 1; i < STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
                thr_q[i] <= thr_q[i-1];
                ctl_q[i] <= ctl_q[i-1];
            end
        end
    end

`ifdef CTRL_PIPE_PARITY_EN
    logic [STAGES-1:0] par_q;
    logic              perr_q;
    logic              par_bad;

    // Parity rides with the word; mismatch at commit flags corruption in flight.
    assign par_bad = vld_q[LAST] & ((^{thr_q[LAST], ctl_q[LAST]}) != par_q[LAST]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q  <= '0;
            perr_q <= 1'b0;
        end else if (bus.flush) begin
            par_q  <= '0;
            perr_q <= 1'b0;
        end else begin
            par_q[0] <= ^{bus.issue_thread, issue_word};
            for (int i = 1; i < STAGES; i++) begin
                par_q[i] <= par_q[i-1];
            end
            perr_q <= perr_q | par_bad;
        end
    end

    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
        localparam int P = int'(TAP_POS[8*k +: 8]);
        assign bus.tap_valid[k]                = vld_q[P];
        assign bus.tap_thread[k*TH_W +: TH_W]  = thr_q[P];
        assign bus.tap_ctrl[k*CTRL_W +: CTRL_W] = ctl_q[P];
    end

    assign bus.wr_ctrl   = ctl_q[LAST];
    assign bus.wr_thread = thr_q[LAST];
    assign bus.wr_valid  = vld_q[LAST] & bus.thread_en[thr_q[LAST]];

    always_comb begin
        inflight_d = inflight_q;
        if (bus.flush) begin
            inflight_d = '0;
        end else if (accept && !retire && inflight_q != IF_W'(STAGES)) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!accept && retire && inflight_q != '0) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    // A flush while busy freezes the count; only an idle flush clears it.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.flush) begin
            if (!bus.busy) cnt_d = '0;
        end else if (bus.busy && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= '0;
            cnt_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.inflight  = inflight_q;
    assign bus.cycle_cnt = cnt_q;
    assign bus.drained   = (inflight_q == '0) && !bus.issue_valid;
endmodule

// File: tb/tb_ctrl_pipe_tracker.sv
// Directed bench for ctrl_pipe_tracker: latency, streaming, masking, flush,
// counter saturation, async reset and (with CTRL_PIPE_PARITY_EN) parity.
module tb_ctrl_pipe_tracker;
    localparam logic [39:0] TAPS = {8'd68, 8'd67, 8'd66, 8'd65, 8'd2};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    ctrl_pipe_tracker_if #(.CTRL_W(27), .STAGES(69), .N_TAPS(5),
                           .THREADS(4), .CNT_W(24)) bus ();
    ctrl_pipe_tracker_if #(.CTRL_W(27), .STAGES(69), .N_TAPS(5),
                           .THREADS(4), .CNT_W(4)) bus2 ();

    ctrl_pipe_tracker #(.CTRL_W(27), .STAGES(69), .N_TAPS(5), .TAP_POS(TAPS),
                        .THREADS(4), .CNT_W(24)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    ctrl_pipe_tracker #(.CTRL_W(27), .STAGES(69), .N_TAPS(5), .TAP_POS(TAPS),
                        .THREADS(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.flush = 1'b0;
        bus.busy = 1'b0;
        bus.issue_valid = 1'b0;
        bus.issue_ctrl = '0;
        bus.issue_thread = '0;
        bus.thread_en = 4'hF;
        bus2.flush = 1'b0;
        bus2.busy = 1'b0;
        bus2.issue_valid = 1'b0;
        bus2.issue_ctrl = '0;
        bus2.issue_thread = '0;
        bus2.thread_en = 4'hF;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.tap_valid !== 5'b0 || bus.wr_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid tap=%b wr=%b exp 0", bus.tap_valid, bus.wr_valid);
        end
        checks++;
        if (bus.tap_ctrl !== '0 || bus.tap_thread !== '0) begin
            failures++;
            $display("FAIL reset_tapdata ctrl=%h thr=%h exp 0", bus.tap_ctrl, bus.tap_thread);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.inflight !== 7'd0 || bus.drained !== 1'b1) begin
            failures++;
            $display("FAIL reset_inflight got=%0d drained=%b exp 0/1", bus.inflight, bus.drained);
        end
        checks++;
        if (bus.cycle_cnt !== 24'd0 || bus.parity_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_cnt cnt=%0d perr=%b exp 0/0", bus.cycle_cnt, bus.parity_err);
        end
    endtask

    task automatic test_single_issue;
        logic [6:0] exp_if;
        bus.issue_valid = 1'b1;
        bus.issue_ctrl = 27'h155;
        bus.issue_thread = 2'd2;
        tick();
        bus.issue_valid = 1'b0;
        bus.issue_ctrl = '0;
        for (int n = 1; n <= 72; n++) begin
            exp_if = (n <= 69) ? 7'd1 : 7'd0;
            checks++;
            if (bus.tap_valid[0] !== (n == 3) || bus.tap_valid[1] !== (n == 66)) begin
                failures++;
                $display("FAIL single_tap n=%0d got=%b", n, bus.tap_valid);
            end
            checks++;
            if (bus.wr_valid !== (n == 69)) begin
                failures++;
                $display("FAIL single_wr n=%0d got=%b exp=%b", n, bus.wr_valid, n == 69);
            end
            checks++;
            if (bus.inflight !== exp_if || bus.drained !== (n >= 70)) begin
                failures++;
                $display("FAIL single_inflight n=%0d got=%0d/%b exp=%0d/%b",
                         n, bus.inflight, bus.drained, exp_if, n >= 70);
            end
            if (n == 3) begin
                checks++;
                if (bus.tap_ctrl[26:0] !== 27'h155 || bus.tap_thread[1:0] !== 2'd2) begin
                    failures++;
                    $display("FAIL single_tap0_data got=%h/%0d exp 155/2",
                             bus.tap_ctrl[26:0], bus.tap_thread[1:0]);
                end
            end
            if (n == 69) begin
                checks++;
                if (bus.wr_ctrl !== 27'h155 || bus.wr_thread !== 2'd2) begin
                    failures++;
                    $display("FAIL single_wr_data got=%h/%0d exp 155/2",
                             bus.wr_ctrl, bus.wr_thread);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        logic [6:0] exp_if;
        bus.thread_en = 4'hF;
        for (int i = 0; i < 100; i++) begin
            bus.issue_valid = 1'b1;
            bus.issue_ctrl = 27'(i);
            bus.issue_thread = 2'(i % 4);
            tick();
            exp_if = (i + 1 < 69) ? 7'(i + 1) : 7'd69;
            checks++;
            if (bus.inflight !== exp_if) begin
                failures++;
                $display("FAIL b2b_fill i=%0d got=%0d exp=%0d", i, bus.inflight, exp_if);
            end
            if (i + 1 >= 69) begin
                checks++;
                if (bus.wr_valid !== 1'b1 || bus.wr_ctrl !== 27'(i + 1 - 69)) begin
                    failures++;
                    $display("FAIL b2b_order i=%0d got=%b/%0d exp=1/%0d",
                             i, bus.wr_valid, bus.wr_ctrl, i + 1 - 69);
                end
            end
        end
        bus.issue_valid = 1'b0;
        bus.issue_ctrl = '0;
        for (int k = 1; k <= 69; k++) begin
            tick();
            exp_if = 7'(69 - k);
            checks++;
            if (bus.inflight !== exp_if) begin
                failures++;
                $display("FAIL b2b_drain k=%0d got=%0d exp=%0d", k, bus.inflight, exp_if);
            end
        end
        checks++;
        if (bus.drained !== 1'b1) begin
            failures++;
            $display("FAIL b2b_drained got=%b exp=1", bus.drained);
        end
    endtask

    task automatic test_thread_mask;
        bus.thread_en = 4'b0101;
        for (int j = 0; j < 4; j++) begin
            bus.issue_valid = 1'b1;
            bus.issue_ctrl = 27'(16 + j);
            bus.issue_thread = 2'(j);
            tick();
        end
        bus.issue_valid = 1'b0;
        bus.issue_ctrl = '0;
        for (int c = 4; c <= 75; c++) begin
            checks++;
            if (bus.wr_valid !== (c == 69 || c == 71)) begin
                failures++;
                $display("FAIL mask_wr c=%0d got=%b thr=%0d", c, bus.wr_valid, bus.wr_thread);
            end
            if (c == 70) begin
                checks++;
                if (bus.wr_thread !== 2'd1 || bus.wr_ctrl !== 27'h11) begin
                    failures++;
                    $display("FAIL mask_gated_data got=%0d/%h exp 1/11",
                             bus.wr_thread, bus.wr_ctrl);
                end
            end
            if (c == 71) begin
                checks++;
                if (bus.wr_thread !== 2'd2 || bus.wr_ctrl !== 27'h12) begin
                    failures++;
                    $display("FAIL mask_commit_data got=%0d/%h exp 2/12",
                             bus.wr_thread, bus.wr_ctrl);
                end
            end
            tick();
        end
        checks++;
        if (bus.inflight !== 7'd0) begin
            failures++;
            $display("FAIL mask_inflight got=%0d exp=0", bus.inflight);
        end
        bus.thread_en = 4'hF;
    endtask

    task automatic test_flush;
        int wr_seen;
        wr_seen = 0;
        bus.busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.issue_valid = 1'b1;
            bus.issue_ctrl = 27'(100 + i);
            bus.issue_thread = 2'(i % 4);
            tick();
        end
        checks++;
        if (bus.cycle_cnt !== 24'd20 || bus.inflight !== 7'd20) begin
            failures++;
            $display("FAIL flush_pre cnt=%0d inflight=%0d exp 20/20", bus.cycle_cnt, bus.inflight);
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.issue_valid = 1'b0;
        bus.issue_ctrl = '0;
        checks++;
        if (bus.tap_valid !== 5'b0 || bus.inflight !== 7'd0) begin
            failures++;
            $display("FAIL flush_clear tap=%b inflight=%0d exp 0/0", bus.tap_valid, bus.inflight);
        end
        checks++;
        if (bus.cycle_cnt !== 24'd20) begin
            failures++;
            $display("FAIL flush_busy_hold cnt=%0d exp=20", bus.cycle_cnt);
        end
        for (int k = 0; k < 80; k++) begin
            tick();
            if (bus.wr_valid === 1'b1) wr_seen++;
        end
        checks++;
        if (wr_seen != 0) begin
            failures++;
            $display("FAIL flush_no_wr got=%0d pulses exp=0", wr_seen);
        end
        checks++;
        if (bus.cycle_cnt !== 24'd100) begin
            failures++;
            $display("FAIL flush_resume cnt=%0d exp=100", bus.cycle_cnt);
        end
        bus.busy = 1'b0;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++;
        if (bus.cycle_cnt !== 24'd0) begin
            failures++;
            $display("FAIL flush_idle_clear cnt=%0d exp=0", bus.cycle_cnt);
        end
    endtask

    task automatic test_saturation;
        logic [3:0] exp_c;
        bus2.busy = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            exp_c = (n < 15) ? 4'(n) : 4'd15;
            checks++;
            if (bus2.cycle_cnt !== exp_c) begin
                failures++;
                $display("FAIL sat_cnt n=%0d got=%0d exp=%0d", n, bus2.cycle_cnt, exp_c);
            end
        end
        bus2.busy = 1'b0;
    endtask

    task automatic test_async_reset;
        bus.busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.issue_valid = 1'b1;
            bus.issue_ctrl = 27'h7A0 + 27'(i);
            bus.issue_thread = 2'(i % 4);
            tick();
        end
        bus.issue_valid = 1'b0;
        bus.issue_ctrl = '0;
        checks++;
        if (bus.tap_valid[0] !== 1'b1 || bus.inflight !== 7'd5 || bus.cycle_cnt !== 24'd5) begin
            failures++;
            $display("FAIL arst_pre tap0=%b inflight=%0d cnt=%0d exp 1/5/5",
                     bus.tap_valid[0], bus.inflight, bus.cycle_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.tap_valid !== 5'b0 || bus.tap_ctrl !== '0 || bus.wr_valid !== 1'b0) begin
            failures++;
            $display("FAIL arst_taps tap=%b ctrl=%h wr=%b exp 0",
                     bus.tap_valid, bus.tap_ctrl, bus.wr_valid);
        end
        checks++;
        if (bus.inflight !== 7'd0 || bus.cycle_cnt !== 24'd0 || bus2.cycle_cnt !== 4'd0
            || bus.drained !== 1'b1) begin
            failures++;
            $display("FAIL arst_status inflight=%0d cnt=%0d cnt2=%0d drained=%b exp 0/0/0/1",
                     bus.inflight, bus.cycle_cnt, bus2.cycle_cnt, bus.drained);
        end
        bus.busy = 1'b0;
        #3;
        rst = 1'b0;
        tick();
    endtask

`ifdef CTRL_PIPE_PARITY_EN
    task automatic test_parity;
        bus.issue_valid = 1'b1;
        bus.issue_ctrl = 27'h3;
        bus.issue_thread = 2'd1;
        tick();
        bus.issue_valid = 1'b0;
        bus.issue_ctrl = '0;
        for (int n = 1; n <= 75; n++) begin
            if (n == 41) dut.ctl_q[40] = dut.ctl_q[40] ^ 27'h8;
            if (n == 69 || n == 70 || n == 75) begin
                checks++;
                if (bus.parity_err !== (n >= 70)) begin
                    failures++;
                    $display("FAIL parity_err n=%0d got=%b exp=%b", n, bus.parity_err, n >= 70);
                end
            end
            tick();
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++;
        if (bus.parity_err !== 1'b0) begin
            failures++;
            $display("FAIL parity_flush got=%b exp=0", bus.parity_err);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single_issue();
        test_back_to_back();
        test_thread_mask();
        test_flush();
        test_saturation();
        test_async_reset();
`ifdef CTRL_PIPE_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
